// File: rtl/mcycle_seq.sv
// mcycle_seq -- multi-cycle unsigned multiply / divide sequencer.
//
// Performs one algorithm step per clock for WIDTH clocks. It uses shift-add
// multiplication or restoring division, and the results are registered.
//
// Ports:
//   CLK       in   clock, rising-edge active
//   RESET_N   in   asynchronous active-low reset
//   Start     in   begin an operation (sampled only while idle)
//   MCycleOp  in   0 = unsigned multiply, 1 = unsigned divide
//   Operand1  in   multiplicand / dividend
//   Operand2  in   multiplier / divisor
//   Result1   out  product low half / quotient
//   Result2   out  product high half / remainder
//   Busy      out  high while an operation is in flight
//   Done      out  one-cycle pulse when new results are valid
module mcycle_seq #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COMPUTE = 1'b1
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic               op_r;
    logic [WIDTH-1:0]   opnd_r;      // multiplicand (mul) or divisor (div)
    logic [2*WIDTH-1:0] acc_r;       // {high, multiplier} or {remainder, dividend/quotient}
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   res1_r;
    logic [WIDTH-1:0]   res2_r;
    logic               busy_r;
    logic               done_r;

    logic               accept_s;
    logic               last_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH:0]     rem_sh_s;
    logic               ge_s;
    logic [WIDTH-1:0]   diff_s;
    logic [2*WIDTH-1:0] div_next_s;
    logic [2*WIDTH-1:0] step_s;

    // One multiply or divide step computed from the current accumulator
    always_comb begin
        sum_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
        mul_next_s = {1'b0, acc_r[2*WIDTH-1:1]};
        if (acc_r[0]) begin
            // The adder carry becomes the new MSB after the right shift.
            mul_next_s = {sum_s, acc_r[WIDTH-1:1]};
        end else begin
            mul_next_s = {1'b0, acc_r[2*WIDTH-1:1]};
        end

        // The shifted remainder can need WIDTH+1 bits before the trial subtract.
        rem_sh_s   = acc_r[2*WIDTH-1:WIDTH-1];
        ge_s       = (rem_sh_s >= {1'b0, opnd_r});
        // Modulo-2^WIDTH difference is exact whenever ge_s holds.
        diff_s     = rem_sh_s[WIDTH-1:0] - opnd_r;
        div_next_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        if (ge_s) begin
            div_next_s = {diff_s, acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end

        step_s = mul_next_s;
        if (op_r) begin
            step_s = div_next_s;
        end else begin
            step_s = mul_next_s;
        end
    end

    // Next-state decode for the IDLE / COMPUTE controller
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (Start) begin
                    accept_s     = 1'b1;
                    next_state_s = COMPUTE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            COMPUTE: begin
                if (cnt_r == LAST_STEP) begin
                    last_s       = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = COMPUTE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand latch, iteration datapath and registered outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            op_r   <= 1'b0;
            opnd_r <= {WIDTH{1'b0}};
            acc_r  <= {(2*WIDTH){1'b0}};
            cnt_r  <= {CW{1'b0}};
            res1_r <= {WIDTH{1'b0}};
            res2_r <= {WIDTH{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept_s) begin
                op_r   <= MCycleOp;
                // Multiply keeps the multiplicand aside and shifts the multiplier
                // through the accumulator; divide does the same with divisor/dividend.
                if (MCycleOp) begin
                    opnd_r <= Operand2;
                    acc_r  <= {{WIDTH{1'b0}}, Operand1};
                end else begin
                    opnd_r <= Operand1;
                    acc_r  <= {{WIDTH{1'b0}}, Operand2};
                end
                cnt_r  <= {CW{1'b0}};
                busy_r <= 1'b1;
            end else if (state_r == COMPUTE) begin
                acc_r <= step_s;
                if (last_s) begin
                    res1_r <= step_s[WIDTH-1:0];
                    res2_r <= step_s[2*WIDTH-1:WIDTH];
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    cnt_r  <= {CW{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end else begin
                busy_r <= 1'b0;
            end
        end
    end

    assign Result1 = res1_r;
    assign Result2 = res2_r;
    assign Busy    = busy_r;
    assign Done    = done_r;

endmodule

// File: doc/mcycle_seq.md
MCYCLE_SEQ -- requirements
Module: mcycle_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; legal range 4..32.
REQ-002 CLK  input  1  clock; all state updates on the rising edge.
REQ-003 RESET_N  input  1  asynchronous, active-low reset.
REQ-004 Start  input  1  request to begin an operation; sampled only while idle.
REQ-005 MCycleOp  input  1  operation select: 0 = unsigned multiply, 1 = unsigned divide.
REQ-006 Operand1  input  WIDTH  multiplicand or dividend.
REQ-007 Operand2  input  WIDTH  multiplier or divisor.
REQ-008 Result1  output  WIDTH  low half of the product, or the quotient.
REQ-009 Result2  output  WIDTH  high half of the product, or the remainder.
REQ-010 Busy  output  1  high while an operation is in progress.
REQ-011 Done  output  1  single-cycle pulse that marks valid new results.

Function
REQ-012 The block SHALL contain an FSM with two states: IDLE and COMPUTE.
REQ-013 In IDLE, at a rising edge with Start=1, the block SHALL do all of the following:
- latch Operand1, Operand2 and MCycleOp;
- clear the iteration counter;
- enter COMPUTE, with Busy=1 from that edge.
REQ-014 In IDLE with Start=0, the block SHALL hold all outputs, with Busy=0.
REQ-015 COMPUTE SHALL perform exactly one algorithm step per clock, for WIDTH steps.
- The counter SHALL be $clog2(WIDTH)+1 bits wide.
- The counter SHALL not wrap before the final step.
REQ-016 Multiply SHALL use shift-add on a 2*WIDTH accumulator with a WIDTH+1-bit adder, keeping the carry. Each step:
- if multiplier LSB=1, add the multiplicand to the upper half;
- then shift the accumulator right by 1.
REQ-017 Divide SHALL use restoring division. Each step:
- shift {remainder, dividend} left by 1;
- trial-subtract the divisor from the remainder;
- if the result is non-negative, keep the difference and set quotient bit 1; otherwise restore and set quotient bit 0.
REQ-018 On the edge completing step WIDTH, the block SHALL do all of the following:
- write Result1 and Result2;
- assert Done for exactly one cycle;
- drive Busy to 0;
- return to IDLE.
REQ-019 Latency: with Start sampled at edge N, Busy SHALL be high for cycles N..N+WIDTH-1, and Done SHALL be high in the cycle after edge N+WIDTH.
REQ-020 Start asserted while Busy=1 SHALL be ignored, with no effect on the operation in flight or on the latched operands.
REQ-021 Start=1 in the cycle where Done=1 SHALL be accepted, giving back-to-back operations with no idle gap.
REQ-022 Changes to Operand1, Operand2 or MCycleOp during COMPUTE SHALL not affect the result.
REQ-023 Result1 and Result2 SHALL hold their values until the next Done; they SHALL not change during COMPUTE.
REQ-024 Divide by zero SHALL take normal latency and produce Result1 = all ones and Result2 = dividend, with no extra flag.
REQ-025 A multiply by zero and a divide with dividend < divisor SHALL still take the full WIDTH cycles; there SHALL be no early termination.
REQ-026 Done and Busy SHALL never be high in the same cycle.

Reset
REQ-027 RESET_N=0 SHALL immediately force all of the following: state IDLE, Busy=0, Done=0, Result1=0, Result2=0, counter=0, internal operand and accumulator registers=0.
REQ-028 Reset asserted mid-COMPUTE SHALL abort the operation without producing a Done pulse.
REQ-029 After RESET_N returns to 1, the first rising edge with Start=1 SHALL begin a fresh operation.

Verification
REQ-030 Basic multiply, WIDTH=32: MCycleOp=0, Operand1=7, Operand2=6, one-cycle Start.
- Required: Busy high for 32 cycles, then Done pulse, Result1=0x0000002A, Result2=0x00000000.
REQ-031 Maximum multiply: 0xFFFFFFFF x 0xFFFFFFFF.
- Required: Result2=0xFFFFFFFE, Result1=0x00000001, proving the carry out of the adder is kept.
REQ-032 Divide: MCycleOp=1, 100 / 7.
- Required: Result1=0x0000000E, Result2=0x00000002.
- Also 0x1A / 0: required Result1=0xFFFFFFFF, Result2=0x0000001A.
REQ-033 Start-while-busy: start 7 x 6, then at cycle 10 pulse Start with MCycleOp=1, Operand1=100, Operand2=7.
- Required: a single Done and Result1=42 (second request ignored).
- Also Start held high at the Done cycle: required second operation begins, second Done exactly 33 cycles after the first.
REQ-034 Reset mid-operation: start a divide, drop RESET_N at cycle 15.
- Required: Busy=0, Result1=Result2=0 immediately, and no Done pulse.
- Then run 3 x 5: required Result1=15.
